// File: rtl/crc_pkg.sv
// Shared types and bit helpers for the parallel CRC engine: width/state
// enums, active-width masks and the reflect functions used on input and output.
package crc_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    CRC8  = 2'b00,
    CRC16 = 2'b01,
    CRC32 = 2'b10
  } crc_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic legal_width(input logic [1:0] w);
    return (w != 2'b11);
  endfunction

  function automatic logic [5:0] width_bits(input crc_width_e w);
    logic [5:0] n;
    case (w)
      CRC8:    n = 6'd8;
      CRC16:   n = 6'd16;
      CRC32:   n = 6'd32;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] msb_index(input crc_width_e w);
    logic [4:0] n;
    case (w)
      CRC8:    n = 5'd7;
      CRC16:   n = 5'd15;
      CRC32:   n = 5'd31;
      default: n = 5'd31;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] width_mask(input crc_width_e w);
    logic [31:0] m;
    case (w)
      CRC8:    m = 32'h0000_00FF;
      CRC16:   m = 32'h0000_FFFF;
      CRC32:   m = 32'hFFFF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // Reverse all 32 bits, then slide the active field back down to bit 0.
  function automatic logic [31:0] reflect_w(input logic [31:0] v, input crc_width_e w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r >> (6'd32 - width_bits(w));
  endfunction

endpackage

// File: rtl/crc_engine_par_if.sv
// Configuration, input-stream and result-stream signals of crc_engine_par.
interface crc_engine_par_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        cfg_width;
  logic [31:0]       cfg_poly;
  logic [31:0]       cfg_init;
  logic [31:0]       cfg_xorout;
  logic              cfg_refin;
  logic              cfg_refout;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       crc_out;
  logic              cfg_err;

  modport master (
    output start, cfg_width, cfg_poly, cfg_init, cfg_xorout, cfg_refin, cfg_refout,
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, crc_out, cfg_err
  );

  modport slave (
    input  start, cfg_width, cfg_poly, cfg_init, cfg_xorout, cfg_refin, cfg_refout,
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, crc_out, cfg_err
  );
endinterface

// File: rtl/crc_step.sv
// Combinational one-byte CRC update, MSB-first, over a runtime-selected width.
// Bits above the active width are forced to zero on every shift.
module crc_step
  import crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  input  logic [31:0] poly,
  input  crc_width_e  width,
  output logic [31:0] crc_out
);

  logic [31:0] mask_s;
  logic [31:0] poly_s;
  logic [4:0]  msb_s;
  logic [31:0] acc_s;
  logic        fb_s;

  // Eight unrolled shift/XOR steps, input byte consumed bit 7 first.
  always_comb begin
    mask_s = width_mask(width);
    poly_s = poly & mask_s;
    msb_s  = msb_index(width);
    acc_s  = crc_in & mask_s;
    fb_s   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb_s  = acc_s[msb_s] ^ data[7-i];
      acc_s = (acc_s << 1) & mask_s;
      if (fb_s) begin
        acc_s = acc_s ^ poly_s;
      end else begin
        acc_s = acc_s;
      end
    end
    crc_out = acc_s;
  end

endmodule

// File: rtl/crc_engine_par.sv
// Parallel CRC-8/16/32 engine: DATA_W/8 chained byte steps per beat, per-frame
// configuration latched on start, result held on a valid/ready port until taken.
module crc_engine_par
  import crc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  crc_engine_par_if.slave bus
);

  localparam int NB = DATA_W / 8;

  state_e      state_r;
  crc_width_e  width_r;
  logic [31:0] poly_r;
  logic [31:0] xorout_r;
  logic        refin_r;
  logic        refout_r;
  logic [31:0] crc_r;
  logic        s_ready_r;
  logic        m_valid_r;
  logic [31:0] crc_out_r;
  logic        cfg_err_r;

  logic [31:0] chain_s [0:NB];
  logic [7:0]  byte_s  [0:NB-1];
  crc_width_e  new_width_s;
  logic        start_ok_s;
  logic        accept_s;
  logic [31:0] fold_s;
  logic [31:0] final_s;

  assign chain_s[0]  = crc_r;
  assign new_width_s = crc_width_e'(bus.cfg_width);
  assign start_ok_s  = legal_width(bus.cfg_width);
  assign accept_s    = bus.s_valid && s_ready_r;

  // Leftmost byte of the beat enters the chain first.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign byte_s[k] = refin_r ? reflect8(bus.s_data[DATA_W-1-8*k -: 8])
                               : bus.s_data[DATA_W-1-8*k -: 8];

    crc_step u_step (
      .crc_in  (chain_s[k]),
      .data    (byte_s[k]),
      .poly    (poly_r),
      .width   (width_r),
      .crc_out (chain_s[k+1])
    );
  end

  // Final value from the register as it will be after the current beat.
  always_comb begin
    fold_s = 32'h0000_0000;
    if (refout_r) begin
      fold_s = reflect_w(chain_s[NB], width_r);
    end else begin
      fold_s = chain_s[NB];
    end
    final_s = (fold_s ^ xorout_r) & width_mask(width_r);
  end

  // Frame FSM, config latch, CRC register and result hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      width_r   <= CRC8;
      poly_r    <= 32'h0000_0000;
      xorout_r  <= 32'h0000_0000;
      refin_r   <= 1'b0;
      refout_r  <= 1'b0;
      crc_r     <= 32'h0000_0000;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      crc_out_r <= 32'h0000_0000;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      if (bus.start) begin
        // Start overrides any beat or m_ready seen in the same cycle.
        m_valid_r <= 1'b0;
        crc_out_r <= 32'h0000_0000;
        if (start_ok_s) begin
          width_r   <= new_width_s;
          poly_r    <= bus.cfg_poly & width_mask(new_width_s);
          xorout_r  <= bus.cfg_xorout & width_mask(new_width_s);
          refin_r   <= bus.cfg_refin;
          refout_r  <= bus.cfg_refout;
          crc_r     <= bus.cfg_init & width_mask(new_width_s);
          state_r   <= RUN;
          s_ready_r <= 1'b1;
        end else begin
          cfg_err_r <= 1'b1;
          state_r   <= IDLE;
          s_ready_r <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            s_ready_r <= 1'b0;
          end
          RUN: begin
            if (accept_s) begin
              crc_r <= chain_s[NB];
              if (bus.s_last) begin
                state_r   <= DONE;
                s_ready_r <= 1'b0;
                m_valid_r <= 1'b1;
                crc_out_r <= final_s;
              end
            end
          end
          DONE: begin
            if (bus.m_ready) begin
              state_r   <= IDLE;
              m_valid_r <= 1'b0;
              crc_out_r <= 32'h0000_0000;
            end
          end
          default: begin
            state_r   <= IDLE;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.crc_out = crc_out_r;
  assign bus.cfg_err = cfg_err_r;

endmodule

// File: tb/tb_crc_engine_par.sv
// Directed bench for crc_engine_par: catalogue check values on an 8-bit build,
// model-derived values on a 32-bit build, backpressure, abort, error and reset.
module tb_crc_engine_par;
  import crc_pkg::*;

  typedef struct packed {
    logic [1:0]  w;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xorout;
    logic        refin;
    logic        refout;
  } cfg_t;

  localparam cfg_t C_ISO  = '{2'b10, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
  localparam cfg_t C_C    = '{2'b10, 32'h1EDC6F41, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
  localparam cfg_t C_8    = '{2'b00, 32'h00000007, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
  localparam cfg_t C_CCIT = '{2'b01, 32'h00001021, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b0};
  localparam cfg_t C_ARC  = '{2'b01, 32'h00008005, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
  localparam cfg_t C_BAD  = '{2'b11, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc_engine_par_if #(.DATA_W(8))  bus8();
  crc_engine_par_if #(.DATA_W(32)) bus32();

  crc_engine_par #(.DATA_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  crc_engine_par #(.DATA_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  msg   [$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0]  msg8  [$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Byte-at-a-time reference: XOR byte into the top, then eight conditional shifts.
  function automatic logic [31:0] crc_model(input cfg_t c, input logic [7:0] d [$]);
    int          wb;
    logic [31:0] msk, r, rr, p;
    logic [7:0]  b;
    wb  = (c.w == 2'b00) ? 8 : (c.w == 2'b01) ? 16 : 32;
    msk = (wb == 32) ? 32'hFFFFFFFF : ((32'd1 << wb) - 32'd1);
    r   = c.init & msk;
    p   = c.poly & msk;
    foreach (d[i]) begin
      for (int j = 0; j < 8; j++) b[j] = c.refin ? d[i][7-j] : d[i][j];
      r = r ^ ({24'h0, b} << (wb - 8));
      for (int j = 0; j < 8; j++) begin
        if (r[wb-1]) r = ((r << 1) ^ p) & msk;
        else         r = (r << 1) & msk;
      end
    end
    if (c.refout) begin
      rr = 32'h0;
      for (int j = 0; j < wb; j++) rr[j] = r[wb-1-j];
      r = rr;
    end
    return (r ^ c.xorout) & msk;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input cfg_t c);
    bus8.start      = 1'b1;
    bus8.cfg_width  = c.w;
    bus8.cfg_poly   = c.poly;
    bus8.cfg_init   = c.init;
    bus8.cfg_xorout = c.xorout;
    bus8.cfg_refin  = c.refin;
    bus8.cfg_refout = c.refout;
    tick;
    bus8.start      = 1'b0;
    // Scramble config after start; the engine must ignore it.
    bus8.cfg_poly   = $urandom;
    bus8.cfg_init   = $urandom;
    bus8.cfg_xorout = $urandom;
    bus8.cfg_refin  = ~c.refin;
    bus8.cfg_refout = ~c.refout;
  endtask

  task automatic feed8(input logic [7:0] d [$], input bit gaps);
    foreach (d[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus8.s_valid = 1'b0;
        tick;
      end
      bus8.s_valid = 1'b1;
      bus8.s_data  = d[i];
      bus8.s_last  = (i == d.size() - 1);
      tick;
    end
    bus8.s_valid = 1'b0;
    bus8.s_last  = 1'b0;
  endtask

  task automatic collect8(input string tag);
    int          n;
    logic [31:0] e;
    n = 0;
    while (!bus8.m_valid && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check(tag, bus8.crc_out, e);
    bus8.m_ready = 1'b1;
    tick;
    bus8.m_ready = 1'b0;
    check1({tag, "_idle"}, bus8.m_valid, 1'b0);
  endtask

  task automatic run32(input string tag, input cfg_t c, input logic [7:0] d [$]);
    int n;
    exp_q.push_back(crc_model(c, d));
    bus32.start      = 1'b1;
    bus32.cfg_width  = c.w;
    bus32.cfg_poly   = c.poly;
    bus32.cfg_init   = c.init;
    bus32.cfg_xorout = c.xorout;
    bus32.cfg_refin  = c.refin;
    bus32.cfg_refout = c.refout;
    tick;
    bus32.start = 1'b0;
    for (int i = 0; i < d.size(); i += 4) begin
      bus32.s_valid = 1'b1;
      bus32.s_data  = {d[i], d[i+1], d[i+2], d[i+3]};
      bus32.s_last  = (i + 4 >= d.size());
      tick;
    end
    bus32.s_valid = 1'b0;
    bus32.s_last  = 1'b0;
    n = 0;
    while (!bus32.m_valid && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd0);
    check(tag, bus32.crc_out, exp_q.pop_front());
    bus32.m_ready = 1'b1;
    tick;
    bus32.m_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    rst_n = 1'b0;
    {bus8.start, bus8.cfg_width, bus8.cfg_poly, bus8.cfg_init, bus8.cfg_xorout} = '0;
    {bus8.cfg_refin, bus8.cfg_refout, bus8.s_valid, bus8.s_data, bus8.s_last, bus8.m_ready} = '0;
    {bus32.start, bus32.cfg_width, bus32.cfg_poly, bus32.cfg_init, bus32.cfg_xorout} = '0;
    {bus32.cfg_refin, bus32.cfg_refout, bus32.s_valid, bus32.s_data, bus32.s_last, bus32.m_ready} = '0;
    tick;
    tick;
    check1("rst_s_ready", bus8.s_ready, 1'b0);
    check1("rst_m_valid", bus8.m_valid, 1'b0);
    check("rst_crc_out", bus8.crc_out, 32'h0);
    check1("rst_cfg_err", bus8.cfg_err, 1'b0);
    rst_n = 1'b1;
    tick;

    // Catalogue check values over "123456789".
    exp_q.push_back(32'hCBF43926); start8(C_ISO);  check1("run_s_ready", bus8.s_ready, 1'b1);
    feed8(msg, 1'b1); collect8("crc32_iso");
    exp_q.push_back(32'h000000F4); start8(C_8);    feed8(msg, 1'b0); collect8("crc8");
    exp_q.push_back(32'h000029B1); start8(C_CCIT); feed8(msg, 1'b1); collect8("crc16_ccitt");
    exp_q.push_back(32'h0000BB3D); start8(C_ARC);  feed8(msg, 1'b0); collect8("crc16_arc");
    exp_q.push_back(32'hE3069283); start8(C_C);    feed8(msg, 1'b1); collect8("crc32c");

    // Backpressure: result held, stray beats ignored.
    exp_q.push_back(32'hCBF43926); start8(C_ISO); feed8(msg, 1'b0);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus8.s_valid = 1'b1;
      bus8.s_data  = 8'($urandom);
      bus8.s_last  = 1'b1;
      check1("bp_m_valid", bus8.m_valid, 1'b1);
      check("bp_crc_out", bus8.crc_out, e);
      check1("bp_s_ready", bus8.s_ready, 1'b0);
      tick;
    end
    bus8.s_valid = 1'b0;
    bus8.s_last  = 1'b0;
    bus8.m_ready = 1'b1;
    tick;
    bus8.m_ready = 1'b0;
    check1("bp_release_m_valid", bus8.m_valid, 1'b0);
    check1("bp_release_s_ready", bus8.s_ready, 1'b0);
    exp_q.push_back(32'h0000BB3D); start8(C_ARC); feed8(msg, 1'b0); collect8("after_bp");

    // Abort mid-frame: prior bytes must be discarded.
    start8(C_8);
    for (int i = 0; i < 3; i++) begin
      bus8.s_valid = 1'b1; bus8.s_data = 8'hA5; bus8.s_last = 1'b0; tick;
    end
    bus8.s_valid = 1'b0;
    exp_q.push_back(32'hCBF43926); start8(C_ISO); feed8(msg, 1'b0); collect8("abort_run");

    // Abort in DONE with m_ready in the same cycle: start wins, result dropped.
    start8(C_8); feed8(msg, 1'b0);
    bus8.m_ready = 1'b1;
    start8(C_ARC);
    bus8.m_ready = 1'b0;
    check1("abort_done_m_valid", bus8.m_valid, 1'b0);
    check1("abort_done_s_ready", bus8.s_ready, 1'b1);
    exp_q.push_back(32'h0000BB3D); feed8(msg, 1'b0); collect8("abort_done");

    // Illegal width from IDLE and from RUN.
    start8(C_BAD);
    check1("err_pulse", bus8.cfg_err, 1'b1);
    check1("err_s_ready", bus8.s_ready, 1'b0);
    tick;
    check1("err_single", bus8.cfg_err, 1'b0);
    check1("err_s_ready2", bus8.s_ready, 1'b0);
    start8(C_ISO);
    start8(C_BAD);
    check1("err_run_pulse", bus8.cfg_err, 1'b1);
    check1("err_run_s_ready", bus8.s_ready, 1'b0);
    tick;

    // Async reset with a result pending, then a clean frame.
    start8(C_ISO); feed8(msg, 1'b0);
    rst_n = 1'b0;
    #2;
    check1("arst_m_valid", bus8.m_valid, 1'b0);
    check("arst_crc_out", bus8.crc_out, 32'h0);
    check1("arst_s_ready", bus8.s_ready, 1'b0);
    check1("arst_cfg_err", bus8.cfg_err, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    exp_q.push_back(32'h000029B1); start8(C_CCIT); feed8(msg, 1'b1); collect8("after_rst");

    // 32-bit beats against the reference model.
    run32("w32_crc32c", C_C, msg8);
    run32("w32_iso", C_ISO, msg8);
    run32("w32_ccitt", C_CCIT, msg8);
    run32("w32_crc8", C_8, msg8);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
